// File: rtl/isr_pkg.sv
// Shared types and defaults for the interrupt/return sequencer.
// Holds the FSM state encoding and the default vector table layout.
package isr_pkg;

  typedef enum logic [1:0] {
    ISR_IDLE,
    ISR_TAKE,
    ISR_IN,
    ISR_RET
  } isr_state_e;

  localparam logic [11:0] ISR_BASE_DEF   = 12'h100;
  localparam logic [11:0] VEC_STRIDE_DEF = 12'h010;

endpackage

// File: rtl/irq_pending.sv
// Edge-latched pending register with lowest-index priority pick.
// Ports: clk, rst, irq_in, ack (one-hot clear) -> any_pending, winner_idx.
module irq_pending #(
  parameter int NUM_IRQ = 4,
  parameter int IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] ack,
  output logic               any_pending,
  output logic [IW-1:0]      winner_idx
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;

  assign rise = irq_in & ~irq_q;

  // A fresh edge wins over a same-cycle ack so it is not dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~ack) | rise;
    end
  end

  always_comb begin
    winner_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) winner_idx = IW'(i);
    end
  end

  assign any_pending = |pending;

endmodule

// File: rtl/isr_controller.sv
// Interrupt entry/return sequencer driving PC redirect and IF/ID flush.
// Ports: irq/pipeline status in; flush pair, isr_pc, ack, status out.
module isr_controller
  import isr_pkg::*;
#(
  parameter int            NUM_IRQ    = 4,
  parameter int            PC_W       = 12,
  parameter logic [PC_W-1:0] ISR_BASE   = PC_W'(ISR_BASE_DEF),
  parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(VEC_STRIDE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_en,
  input  logic [PC_W-1:0]    if_pc,
  input  logic               id_valid,
  input  logic               id_is_ctrl,
  input  logic               id_stall,
  input  logic               exe_stall,
  input  logic               branch_flush,
  input  logic               jump_flush,
  input  logic               exe_is_ret,
  output logic               ISR_PC_flush,
  output logic               ISR_pipe_flush,
  output logic               isr_pc_sel,
  output logic [PC_W-1:0]    isr_pc,
  output logic               isr_active,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [PC_W-1:0]    saved_pc
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  isr_state_e      state;
  isr_state_e      nstate;
  logic            any_pending;
  logic [IW-1:0]   winner_idx;
  logic [IW-1:0]   idx_q;
  logic [PC_W-1:0] saved_q;
  logic            take_ok;

  irq_pending #(
    .NUM_IRQ (NUM_IRQ),
    .IW      (IW)
  ) u_pend (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .ack         (irq_ack),
    .any_pending (any_pending),
    .winner_idx  (winner_idx)
  );

  // Only enter on a plain, moving instruction in ID so the
  // redirect lands on a clean boundary.
  assign take_ok = any_pending & int_en & id_valid
                 & ~id_is_ctrl & ~id_stall
                 & ~branch_flush & ~jump_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ISR_IDLE;
      idx_q   <= '0;
      saved_q <= '0;
    end else begin
      state <= nstate;
      if (state == ISR_IDLE && take_ok) begin
        idx_q   <= winner_idx;
        saved_q <= if_pc;
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ISR_IDLE: if (take_ok) nstate = ISR_TAKE;
      ISR_TAKE: nstate = ISR_IN;
      ISR_IN:   if (exe_is_ret && !exe_stall) nstate = ISR_RET;
      ISR_RET:  nstate = ISR_IDLE;
    endcase
  end

  logic in_take;
  logic in_ret;

  assign in_take = (state == ISR_TAKE);
  assign in_ret  = (state == ISR_RET);

  always_comb begin
    ISR_PC_flush   = 1'b0;
    ISR_pipe_flush = 1'b0;
    isr_pc_sel     = 1'b0;
    isr_pc         = '0;
    irq_ack        = '0;
    unique case (1'b1)
      in_take: begin
        ISR_PC_flush   = 1'b1;
        ISR_pipe_flush = 1'b1;
        isr_pc_sel     = 1'b1;
        isr_pc         = ISR_BASE + PC_W'(idx_q) * VEC_STRIDE;
        irq_ack        = NUM_IRQ'(1) << idx_q;
      end
      in_ret: begin
        ISR_PC_flush   = 1'b1;
        ISR_pipe_flush = 1'b1;
        isr_pc_sel     = 1'b1;
        isr_pc         = saved_q;
      end
      default: ;
    endcase
  end

  assign isr_active = (state == ISR_IN) || (state == ISR_RET);
  assign saved_pc   = saved_q;

endmodule

// File: tb/tb_isr_controller.sv
// Directed bench for isr_controller with a cycle-level reference model.
// Checks every settled cycle plus literal values at key points.
module tb_isr_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        int_en;
  logic [11:0] if_pc;
  logic        id_valid;
  logic        id_is_ctrl;
  logic        id_stall;
  logic        exe_stall;
  logic        branch_flush;
  logic        jump_flush;
  logic        exe_is_ret;
  logic        ISR_PC_flush;
  logic        ISR_pipe_flush;
  logic        isr_pc_sel;
  logic [11:0] isr_pc;
  logic        isr_active;
  logic [3:0]  irq_ack;
  logic [11:0] saved_pc;

  int checks = 0;
  int passed = 0;

  isr_controller dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .int_en         (int_en),
    .if_pc          (if_pc),
    .id_valid       (id_valid),
    .id_is_ctrl     (id_is_ctrl),
    .id_stall       (id_stall),
    .exe_stall      (exe_stall),
    .branch_flush   (branch_flush),
    .jump_flush     (jump_flush),
    .exe_is_ret     (exe_is_ret),
    .ISR_PC_flush   (ISR_PC_flush),
    .ISR_pipe_flush (ISR_pipe_flush),
    .isr_pc_sel     (isr_pc_sel),
    .isr_pc         (isr_pc),
    .isr_active     (isr_active),
    .irq_ack        (irq_ack),
    .saved_pc       (saved_pc)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else
      passed++;
  endfunction

  // Reference model: phase 0 idle, 1 entering, 2 in handler, 3 returning.
  int          m_phase;
  logic [3:0]  m_pend;
  logic [3:0]  m_prev;
  logic [11:0] m_saved;
  int          m_idx;

  logic        e_flush;
  logic [11:0] e_pc;
  logic [3:0]  e_ack;
  logic        e_active;
  logic        m_clean;

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  always_comb begin
    e_flush  = (m_phase == 1) || (m_phase == 3);
    e_active = (m_phase == 2) || (m_phase == 3);
    e_ack    = 4'b0;
    e_pc     = 12'h0;
    if (m_phase == 1) begin
      e_ack = 4'b0001 << m_idx;
      e_pc  = 12'h100 + 12'(m_idx * 16);
    end else if (m_phase == 3) begin
      e_pc = m_saved;
    end
    m_clean = int_en && id_valid && !id_is_ctrl && !id_stall
              && !branch_flush && !jump_flush;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_pend  <= 4'b0;
      m_prev  <= 4'b0;
      m_saved <= 12'h0;
      m_idx   <= 0;
    end else begin
      m_pend <= (m_pend & ~e_ack) | (irq_in & ~m_prev);
      m_prev <= irq_in;
      case (m_phase)
        0: if (m_pend != 0 && m_clean) begin
             m_phase <= 1;
             m_saved <= if_pc;
             m_idx   <= lowest(m_pend);
           end
        1: m_phase <= 2;
        2: if (exe_is_ret && !exe_stall) m_phase <= 3;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pc_flush", 32'(ISR_PC_flush), 32'(e_flush));
      chk("pipe_flush", 32'(ISR_pipe_flush), 32'(e_flush));
      chk("pc_sel", 32'(isr_pc_sel), 32'(e_flush));
      chk("isr_pc", 32'(isr_pc), 32'(e_pc));
      chk("irq_ack", 32'(irq_ack), 32'(e_ack));
      chk("isr_active", 32'(isr_active), 32'(e_active));
      chk("saved_pc", 32'(saved_pc), 32'(m_saved));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_take(input string n, input logic [11:0] pc,
                          input logic [3:0] ack, input logic [11:0] sv);
    chk({n, "_flush"}, 32'(ISR_PC_flush), 32'd1);
    chk({n, "_pipe"}, 32'(ISR_pipe_flush), 32'd1);
    chk({n, "_pc"}, 32'(isr_pc), 32'(pc));
    chk({n, "_ack"}, 32'(irq_ack), 32'(ack));
    chk({n, "_saved"}, 32'(saved_pc), 32'(sv));
  endtask

  task automatic do_return(input string n, input logic [11:0] sv);
    exe_is_ret = 1'b1;
    tick(1);
    chk({n, "_ret_flush"}, 32'(ISR_PC_flush), 32'd1);
    chk({n, "_ret_pc"}, 32'(isr_pc), 32'(sv));
    chk({n, "_ret_active"}, 32'(isr_active), 32'd1);
    exe_is_ret = 1'b0;
    tick(1);
    chk({n, "_idle_flush"}, 32'(ISR_PC_flush), 32'd0);
    chk({n, "_idle_active"}, 32'(isr_active), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_in = 4'b0; int_en = 1'b1; if_pc = 12'h0;
    id_valid = 1'b1; id_is_ctrl = 1'b0; id_stall = 1'b0;
    exe_stall = 1'b0; branch_flush = 1'b0; jump_flush = 1'b0;
    exe_is_ret = 1'b0;
    #1;
    chk("rst_flush", 32'(ISR_PC_flush), 32'd0);
    chk("rst_pc", 32'(isr_pc), 32'd0);
    chk("rst_saved", 32'(saved_pc), 32'd0);
    chk("rst_active", 32'(isr_active), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // single interrupt
    if_pc = 12'h044; irq_in = 4'b0010;
    tick(1);
    chk("t1_wait", 32'(ISR_PC_flush), 32'd0);
    irq_in = 4'b0;
    tick(1);
    lit_take("t1_take", 12'h110, 4'b0010, 12'h044);
    chk("t1_take_active", 32'(isr_active), 32'd0);
    tick(1);
    chk("t1_in_active", 32'(isr_active), 32'd1);
    chk("t1_in_flush", 32'(ISR_PC_flush), 32'd0);
    do_return("t1", 12'h044);

    // deferral by every blocking condition
    if_pc = 12'h2A4; id_stall = 1'b1; irq_in = 4'b0001;
    tick(1);
    irq_in = 4'b0;
    chk("t2_stall0", 32'(ISR_PC_flush), 32'd0);
    tick(2);
    chk("t2_stall2", 32'(ISR_PC_flush), 32'd0);
    id_stall = 1'b0; branch_flush = 1'b1;
    tick(1);
    chk("t2_branch", 32'(ISR_PC_flush), 32'd0);
    branch_flush = 1'b0; jump_flush = 1'b1;
    tick(1);
    chk("t2_jump", 32'(ISR_PC_flush), 32'd0);
    jump_flush = 1'b0; id_is_ctrl = 1'b1;
    tick(1);
    chk("t2_ctrl", 32'(ISR_PC_flush), 32'd0);
    id_is_ctrl = 1'b0; id_valid = 1'b0;
    tick(1);
    chk("t2_invalid", 32'(ISR_PC_flush), 32'd0);
    id_valid = 1'b1;
    tick(1);
    lit_take("t2_take", 12'h100, 4'b0001, 12'h2A4);
    tick(1);
    do_return("t2", 12'h2A4);

    // priority, no nesting, back-to-back
    if_pc = 12'h3C8; irq_in = 4'b1001;
    tick(1);
    irq_in = 4'b0;
    tick(1);
    lit_take("t3_take0", 12'h100, 4'b0001, 12'h3C8);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t3_nonest", 32'(ISR_PC_flush), 32'd0);
    end
    exe_is_ret = 1'b1;
    tick(1);
    chk("t3_ret_pc", 32'(isr_pc), 32'h3C8);
    exe_is_ret = 1'b0;
    if_pc = 12'h3D0;
    tick(1);
    chk("t3_gap", 32'(ISR_PC_flush), 32'd0);
    tick(1);
    lit_take("t3_take3", 12'h130, 4'b1000, 12'h3D0);
    tick(1);
    do_return("t3", 12'h3D0);

    // masking
    int_en = 1'b0; if_pc = 12'h55C; irq_in = 4'b0100;
    tick(1);
    irq_in = 4'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_masked", 32'(ISR_PC_flush), 32'd0);
      tick(1);
    end
    chk("t4_masked_last", 32'(ISR_PC_flush), 32'd0);
    int_en = 1'b1;
    tick(1);
    lit_take("t4_take", 12'h120, 4'b0100, 12'h55C);
    tick(1);
    do_return("t4", 12'h55C);

    // stray return, stalled return, int_en drop inside handler
    exe_is_ret = 1'b1;
    tick(2);
    chk("t5_stray", 32'(ISR_PC_flush), 32'd0);
    exe_is_ret = 1'b0;
    if_pc = 12'h600; irq_in = 4'b1000;
    tick(1);
    irq_in = 4'b0;
    tick(1);
    lit_take("t5_take", 12'h130, 4'b1000, 12'h600);
    tick(1);
    int_en = 1'b0; exe_is_ret = 1'b1; exe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_stalled", 32'(ISR_PC_flush), 32'd0);
      chk("t5_active", 32'(isr_active), 32'd1);
    end
    exe_stall = 1'b0;
    tick(1);
    chk("t5_ret", 32'(ISR_PC_flush), 32'd1);
    chk("t5_ret_pc", 32'(isr_pc), 32'h600);
    exe_is_ret = 1'b0; int_en = 1'b1;
    tick(1);

    // async reset inside handler drops the still-pending source
    if_pc = 12'h7F0; irq_in = 4'b0011;
    tick(1);
    irq_in = 4'b0;
    tick(1);
    lit_take("t6_take", 12'h100, 4'b0001, 12'h7F0);
    tick(1);
    chk("t6_in", 32'(isr_active), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_active", 32'(isr_active), 32'd0);
    chk("t6_rst_flush", 32'(ISR_PC_flush), 32'd0);
    chk("t6_rst_saved", 32'(saved_pc), 32'd0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t6_lost", 32'(ISR_PC_flush), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
